// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops, radix-2 Booth multiply and
// non-restoring divide, driven by a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         start,
  input  logic [4:0]   opcode,
  input  logic [W-1:0] Ra,
  input  logic [W-1:0] Rb,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [W-1:0] ZHI,
  output logic [W-1:0] ZLO
);

  localparam int unsigned CW = SW + 1;

  localparam logic [4:0] OpAdd = 5'b00011;
  localparam logic [4:0] OpSub = 5'b00100;
  localparam logic [4:0] OpShr = 5'b00101;
  localparam logic [4:0] OpShl = 5'b00110;
  localparam logic [4:0] OpRor = 5'b00111;
  localparam logic [4:0] OpRol = 5'b01000;
  localparam logic [4:0] OpAnd = 5'b01001;
  localparam logic [4:0] OpOr  = 5'b01010;
  localparam logic [4:0] OpMul = 5'b01110;
  localparam logic [4:0] OpDiv = 5'b01111;
  localparam logic [4:0] OpNeg = 5'b10000;
  localparam logic [4:0] OpNot = 5'b10001;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  zhi_q, zhi_d, zlo_q, zlo_d;
  // Iteration datapath: acc is the W+1 bit partial product / partial remainder.
  logic [W:0]    acc_q, acc_d;
  logic [W-1:0]  q_q, q_d;
  logic          qm1_q, qm1_d;
  logic [W:0]    m_q, m_d;
  logic          isdiv_q, isdiv_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;

  logic [SW-1:0] n;
  logic [CW-1:0] nc;
  logic [W-1:0]  sc_hi, sc_lo;
  logic          sc_dz;
  logic          is_multi;
  logic [W-1:0]  a_abs, b_abs;
  logic [W:0]    mul_sum, div_sh, div_sum;
  logic [W-1:0]  rem, fin_hi, fin_lo;

  assign n        = Rb[SW-1:0];
  assign nc       = CW'(W) - CW'(n);
  assign is_multi = (opcode == OpMul) || ((opcode == OpDiv) && (Rb != '0));
  assign a_abs    = Ra[W-1] ? -Ra : Ra;
  assign b_abs    = Rb[W-1] ? -Rb : Rb;

  always_comb begin
    sc_hi = '0;
    sc_lo = '0;
    sc_dz = 1'b0;
    case (opcode)
      OpAdd: sc_lo = Ra + Rb;
      OpSub: sc_lo = Ra - Rb;
      OpShr: sc_lo = Ra >> n;
      OpShl: sc_lo = Ra << n;
      OpRor: sc_lo = (Ra >> n) | (Ra << nc);
      OpRol: sc_lo = (Ra << n) | (Ra >> nc);
      OpAnd: sc_lo = Ra & Rb;
      OpOr:  sc_lo = Ra | Rb;
      OpNeg: sc_lo = -Ra;
      OpNot: sc_lo = ~Ra;
      OpDiv: begin
        // Only reached with Rb == 0; nonzero divisors take the iterative path.
        sc_lo = '1;
        sc_hi = Ra;
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   mul_sum = acc_q + m_q;
      2'b10:   mul_sum = acc_q - m_q;
      default: mul_sum = acc_q;
    endcase
    div_sh  = {acc_q[W-1:0], q_q[W-1]};
    div_sum = acc_q[W] ? div_sh + m_q : div_sh - m_q;
    rem     = acc_q[W] ? acc_q[W-1:0] + m_q[W-1:0] : acc_q[W-1:0];
    if (isdiv_q) begin
      fin_lo = neg_q ? -q_q : q_q;
      fin_hi = rneg_q ? -rem : rem;
    end else begin
      fin_lo = q_q;
      fin_hi = acc_q[W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    isdiv_d = isdiv_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_multi) begin
            acc_d   = '0;
            qm1_d   = 1'b0;
            isdiv_d = (opcode == OpDiv);
            neg_d   = Ra[W-1] ^ Rb[W-1];
            rneg_d  = Ra[W-1];
            if (opcode == OpDiv) begin
              q_d = a_abs;
              m_d = {1'b0, b_abs};
            end else begin
              q_d = Rb;
              m_d = {Ra[W-1], Ra};
            end
            cnt_d   = CW'(W);
            busy_d  = 1'b1;
            state_d = StRun;
          end else begin
            zhi_d  = sc_hi;
            zlo_d  = sc_lo;
            dz_d   = sc_dz;
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (isdiv_q) begin
          acc_d = div_sum;
          q_d   = {q_q[W-2:0], ~div_sum[W]};
        end else begin
          acc_d = {mul_sum[W], mul_sum[W:1]};
          q_d   = {mul_sum[0], q_q[W-1:1]};
          qm1_d = q_q[0];
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StFin;
          busy_d  = 1'b0;
        end
      end
      StFin: begin
        zhi_d   = fin_hi;
        zlo_d   = fin_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      isdiv_q <= isdiv_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign ZHI      = zhi_q;
  assign ZLO      = zlo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at W=32 and W=8: stimulus pushes expected results,
// per-instance monitors pop and compare whenever done pulses.
module tb_seq_alu;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, SHR = 5'b00101, SHL = 5'b00110;
  localparam logic [4:0] ROR = 5'b00111, ROL = 5'b01000, AND = 5'b01001, OR  = 5'b01010;
  localparam logic [4:0] MUL = 5'b01110, DIV = 5'b01111, NEG = 5'b10000, NOT = 5'b10001;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        start, start8;
  logic [4:0]  opcode, op8;
  logic [31:0] ra, rb;
  logic [7:0]  ra8, rb8;
  logic        busy, done, dz, busy8, done8, dz8;
  logic [31:0] zhi, zlo;
  logic [7:0]  zhi8, zlo8;

  exp_t q32[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.W(32)) dut32 (
    .clock(clk), .clear(clear), .start(start), .opcode(opcode), .Ra(ra), .Rb(rb),
    .busy(busy), .done(done), .div_zero(dz), .ZHI(zhi), .ZLO(zlo)
  );

  seq_alu #(.W(8)) dut8 (
    .clock(clk), .clear(clear), .start(start8), .opcode(op8), .Ra(ra8), .Rb(rb8),
    .busy(busy8), .done(done8), .div_zero(dz8), .ZHI(zhi8), .ZLO(zlo8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", {zhi, zlo}, 64'hx);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("zhi32", 64'(zhi), 64'(e.hi));
        chk("zlo32", 64'(zlo), 64'(e.lo));
        chk("divzero32", 64'(dz), 64'(e.dz));
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", {zhi8, zlo8}, 64'hx);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("zhi8", 64'(zhi8), 64'(e.hi));
        chk("zlo8", 64'(zlo8), 64'(e.lo));
        chk("divzero8", 64'(dz8), 64'(e.dz));
      end
    end
  end

  // lat_exp counts clock edges after the start edge until the edge that raises done.
  task automatic issue(input bit w8, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input logic edz, input int lat_exp, input string name,
                       output int bcnt);
    exp_t e;
    int   lat;
    e.hi = hi;
    e.lo = lo;
    e.dz = edz;
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; op8 = op; ra8 = a[7:0]; rb8 = b[7:0];
      q8.push_back(e);
    end else begin
      start = 1'b1; opcode = op; ra = a; rb = b;
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start8 = 1'b0;
    ra  = $urandom; rb  = $urandom;
    ra8 = 8'($urandom); rb8 = 8'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!(w8 ? done8 : done) && lat < 200) begin
      bcnt += int'(w8 ? busy8 : busy);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   bc;
    int   lat;
    exp_t e;
    clear = 1'b0;
    start = 1'b0; start8 = 1'b0;
    opcode = '0; op8 = '0;
    ra = '0; rb = '0; ra8 = '0; rb8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset32", {29'b0, busy, done, dz, zhi, zlo}, 64'h0);
    chk("reset8", {45'b0, busy8, done8, dz8, zhi8, zlo8}, 64'h0);
    @(negedge clk);
    clear = 1'b1;

    // Single-cycle ops
    issue(0, ADD, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h00000001, 0, 0, "add", bc);
    issue(0, ROR, 32'h80000001, 32'd4, 32'h0, 32'h18000000, 0, 0, "ror", bc);
    issue(0, ROR, 32'h12345678, 32'd32, 32'h0, 32'h12345678, 0, 0, "ror_n0", bc);
    issue(0, ROL, 32'h80000001, 32'd1, 32'h0, 32'h00000003, 0, 0, "rol", bc);
    issue(0, SHR, 32'hF0000000, 32'd4, 32'h0, 32'h0F000000, 0, 0, "shr", bc);
    issue(0, SHL, 32'h00000001, 32'd31, 32'h0, 32'h80000000, 0, 0, "shl", bc);
    issue(0, AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'h0F000F00, 0, 0, "and", bc);
    issue(0, NEG, 32'd5, 32'd0, 32'h0, 32'hFFFFFFFB, 0, 0, "neg", bc);
    issue(0, NOT, 32'h0, 32'd0, 32'h0, 32'hFFFFFFFF, 0, 0, "not", bc);
    issue(0, 5'b11111, 32'd9, 32'd9, 32'h0, 32'h0, 0, 0, "undef", bc);

    // Multiply / divide
    issue(0, MUL, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, "mul_neg", bc);
    chk("mul_busy_cycles", 64'(bc), 64'd32);
    issue(0, MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, 33, "mul_min", bc);
    issue(0, DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, "div_neg", bc);
    issue(0, DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 33, "div_negb", bc);
    issue(0, DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 33, "div_ovf", bc);
    issue(0, DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 0, "div_zero", bc);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; opcode = MUL; ra = 32'd5; rb = 32'd6;
    e.hi = 32'h0; e.lo = 32'd30; e.dz = 1'b0;
    q32.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == 10) begin
        @(negedge clk);
        start = 1'b1; opcode = ADD; ra = 32'd1; rb = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      lat++;
    end
    chk("busy_ignore_latency", 64'(lat), 64'd33);

    // Reset mid-multiply aborts with no done
    @(negedge clk);
    start = 1'b1; opcode = MUL; ra = 32'd7; rb = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("abort_outputs", {29'b0, busy, done, dz, zhi, zlo}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    repeat (40) @(posedge clk);
    issue(0, SUB, 32'd3, 32'd5, 32'h0, 32'hFFFFFFFE, 0, 0, "sub", bc);

    // Back-to-back single-cycle ops with start held
    @(negedge clk);
    start = 1'b1; opcode = ADD; ra = 32'd1; rb = 32'd2;
    e.hi = 32'h0; e.lo = 32'd3; e.dz = 1'b0; q32.push_back(e);
    @(negedge clk);
    chk("b2b_done1", 64'(done), 64'd1);
    opcode = SUB; ra = 32'd10; rb = 32'd3;
    e.lo = 32'd7; q32.push_back(e);
    @(negedge clk);
    chk("b2b_done2", 64'(done), 64'd1);
    opcode = OR; ra = 32'hF0; rb = 32'h0F;
    e.lo = 32'hFF; q32.push_back(e);
    @(negedge clk);
    chk("b2b_done3", 64'(done), 64'd1);
    start = 1'b0;

    // W=8 instance
    issue(1, MUL, 32'h80, 32'h80, 32'h40, 32'h00, 0, 9, "mul8", bc);
    issue(1, SHL, 32'h11, 32'h0B, 32'h00, 32'h88, 0, 0, "shl8", bc);
    issue(1, DIV, 32'hF9, 32'h02, 32'hFF, 32'hFD, 0, 9, "div8", bc);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue32_drained", 64'(q32.size()), 64'd0);
    chk("queue8_drained", 64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
